uart_tx_sched: RTL and testbench

Transmit-side scheduler between the UART TX FIFO and the transmit shift register. It pops bytes from the FIFO only when the FIFO is non-empty and the transmitter is idle. It absorbs the FIFO's one-cycle registered read latency and hands each byte to the transmitter with a load strobe. It also enforces a configurable inter-frame gap, counts sent frames and raises the TX-threshold interrupt.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx_sched.sv | 97 +++++++++
 tb/tb_uart_tx_sched.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM states and FIFO flag positions.
package uart_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StCapture,
      StLoad,
      StHold,
      StWaitTx,
      StGap
   } tx_state_e;

   localparam int unsigned FIFO_EMPTY_BIT  = 0;
   localparam int unsigned FIFO_FULL_BIT   = 1;
   localparam int unsigned FIFO_AFULL_BIT  = 2;
   localparam int unsigned FIFO_AEMPTY_BIT = 3;

endpackage

// File: rtl/uart_tx_sched.sv
// Pops bytes from the TX FIFO into the shift register one at a time, with an inter-frame gap,
// a wrapping frame counter and a registered TX-threshold interrupt.
module uart_tx_sched
   import uart_pkg::*;
#(
   parameter int unsigned GAP_CYCLES = 2,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 Enable,
   input  logic                 Irq_En,
   input  logic [3:0]           Fifo_Status,
   input  logic [7:0]           Fifo_Data,
   output logic                 Fifo_Read,
   input  logic                 Tx_Ready,
   output logic                 Tx_Load,
   output logic [7:0]           Tx_Data,
   output logic                 Tx_Irq,
   output logic                 Idle,
   output logic [CNT_WIDTH-1:0] Frame_Count
);

   localparam int unsigned GapW = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);
   localparam logic [GapW-1:0]      GapLoad = GapW'(GAP_CYCLES);
   localparam logic [GapW-1:0]      GapOne  = GapW'(1);
   localparam logic [CNT_WIDTH-1:0] CntOne  = CNT_WIDTH'(1);

   tx_state_e            state_q, state_d;
   logic [GapW-1:0]      gap_q, gap_d;
   logic [7:0]           tx_data_q;
   logic [CNT_WIDTH-1:0] frame_cnt_q;
   logic                 irq_q;
   logic                 unused_status;

   assign unused_status = ^{Fifo_Status[FIFO_FULL_BIT], Fifo_Status[FIFO_AFULL_BIT]};

   always_comb begin
      state_d   = state_q;
      gap_d     = gap_q;
      Fifo_Read = 1'b0;
      Tx_Load   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (Enable && !Fifo_Status[FIFO_EMPTY_BIT] && Tx_Ready) state_d = StFetch;
         end
         StFetch: begin
            Fifo_Read = 1'b1;
            state_d   = StCapture;
         end
         StCapture: state_d = StLoad;
         StLoad: begin
            Tx_Load = 1'b1;
            state_d = StHold;
         end
         // Transmitter may still show ready here; it drops within a cycle of the load.
         StHold: state_d = StWaitTx;
         StWaitTx: begin
            if (Tx_Ready) begin
               if (GAP_CYCLES == 0) begin
                  state_d = StIdle;
               end else begin
                  gap_d   = GapLoad;
                  state_d = StGap;
               end
            end
         end
         StGap: begin
            gap_d = gap_q - GapOne;
            if (gap_q <= GapOne) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= StIdle;
         gap_q       <= '0;
         tx_data_q   <= 8'h00;
         frame_cnt_q <= '0;
         irq_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         gap_q   <= gap_d;
         irq_q   <= Irq_En & Fifo_Status[FIFO_AEMPTY_BIT];
         if (state_q == StCapture) tx_data_q <= Fifo_Data;
         if (state_q == StLoad) frame_cnt_q <= frame_cnt_q + CntOne;
      end
   end

   assign Tx_Data     = tx_data_q;
   assign Tx_Irq      = irq_q;
   assign Frame_Count = frame_cnt_q;
   assign Idle        = (state_q == StIdle) && Fifo_Status[FIFO_EMPTY_BIT] && Tx_Ready;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: FIFO and transmitter models plus a byte scoreboard.
module tb_uart_tx_sched;

   localparam int unsigned Gap = 2;
   localparam int unsigned Cw  = 4;

   logic          Clk = 1'b0;
   logic          Reset;
   logic          Enable;
   logic          Irq_En;
   logic          aempty;
   logic          fifo_empty;
   logic [3:0]    Fifo_Status;
   logic [7:0]    Fifo_Data;
   logic          Fifo_Read;
   logic          Tx_Ready;
   logic          Tx_Load;
   logic [7:0]    Tx_Data;
   logic          Tx_Irq;
   logic          Idle;
   logic [Cw-1:0] Frame_Count;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [7:0] mem [64];
   int         rd_ptr = 0;
   int         wr_ptr = 0;
   int         busy_cnt = 0;
   int         busy_len = 3;
   logic [7:0] exp_q [$];

   uart_tx_sched #(.GAP_CYCLES(Gap), .CNT_WIDTH(Cw)) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .Enable     (Enable),
      .Irq_En     (Irq_En),
      .Fifo_Status(Fifo_Status),
      .Fifo_Data  (Fifo_Data),
      .Fifo_Read  (Fifo_Read),
      .Tx_Ready   (Tx_Ready),
      .Tx_Load    (Tx_Load),
      .Tx_Data    (Tx_Data),
      .Tx_Irq     (Tx_Irq),
      .Idle       (Idle),
      .Frame_Count(Frame_Count)
   );

   always #5 Clk = ~Clk;

   assign fifo_empty  = (rd_ptr == wr_ptr);
   assign Fifo_Status = {aempty, 1'b0, 1'b0, fifo_empty};
   assign Tx_Ready    = (busy_cnt == 0);

   always @(posedge Clk) begin
      cyc <= cyc + 1;
      if (Reset) begin
         rd_ptr   <= wr_ptr;
         busy_cnt <= 0;
      end else begin
         if (Fifo_Read) begin
            Fifo_Data <= mem[rd_ptr % 64];
            rd_ptr    <= rd_ptr + 1;
         end
         if (Tx_Load) busy_cnt <= busy_len;
         else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
      end
   end

   // Scoreboard and empty-read guard.
   always @(negedge Clk) begin
      if (!Reset) begin
         if (Fifo_Read) begin
            total++;
            assert (fifo_empty === 1'b0)
               else begin bad++; $error("FAIL read_on_empty: got empty=%0b want 0", fifo_empty); end
         end
         if (Tx_Load) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $error("FAIL unexpected_load: got data=%02h want no load", Tx_Data);
            end else begin
               logic [7:0] e;
               e = exp_q.pop_front();
               assert (Tx_Data === e)
                  else begin bad++; $error("FAIL tx_data: got %02h want %02h", Tx_Data, e); end
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      assert (got === want)
         else begin bad++; $error("FAIL %s: got %0h want %0h", tag, got, want); end
   endtask

   task automatic push(input logic [7:0] b, input bit expect_it);
      mem[wr_ptr % 64] = b;
      wr_ptr = wr_ptr + 1;
      if (expect_it) exp_q.push_back(b);
   endtask

   // which: 0 = Fifo_Read, 1 = Tx_Load, 2 = Idle
   task automatic wait_for(input int which, input string tag, output int t);
      logic s;
      t = -1;
      for (int k = 0; k < 300; k++) begin
         @(negedge Clk);
         s = (which == 0) ? Fifo_Read : (which == 1) ? Tx_Load : Idle;
         if (s) begin
            t = cyc;
            break;
         end
      end
      total++;
      assert (t >= 0) else begin bad++; $error("FAIL timeout_%s: got none want event", tag); end
   endtask

   task automatic quiet(input int n, input string tag);
      int hits = 0;
      for (int k = 0; k < n; k++) begin
         @(negedge Clk);
         if (Fifo_Read || Tx_Load) hits++;
      end
      chk(tag, hits, 0);
   endtask

   initial begin
      int r, l, i;
      int lt [4];
      Reset  = 1'b1;
      Enable = 1'b0;
      Irq_En = 1'b0;
      aempty = 1'b0;
      repeat (3) @(negedge Clk);
      chk("rst_tx_data", Tx_Data, 8'h00);
      chk("rst_frame_count", Frame_Count, 0);
      chk("rst_irq", Tx_Irq, 0);
      chk("rst_read", Fifo_Read, 0);
      chk("rst_load", Tx_Load, 0);
      Reset = 1'b0;
      @(negedge Clk);
      chk("rst_idle", Idle, 1);

      // Single byte: load two cycles after the pop, 3 busy cycles, 2 gap cycles.
      push(8'hA5, 1'b1);
      Enable = 1'b1;
      wait_for(0, "read1", r);
      wait_for(1, "load1", l);
      chk("read_to_load", l - r, 2);
      @(negedge Clk);
      chk("count_after_1", Frame_Count, 1);
      wait_for(2, "idle1", i);
      chk("load_to_idle", i - l, 3 + 1 + Gap + 1);

      // Burst of four bytes, 10 busy cycles each.
      busy_len = 10;
      for (int k = 1; k <= 4; k++) push(8'(k), 1'b1);
      for (int k = 0; k < 4; k++) wait_for(1, "burst_load", lt[k]);
      for (int k = 1; k < 4; k++) chk("burst_period", lt[k] - lt[k-1], 10 + 2 + 5);
      wait_for(2, "burst_idle", i);
      chk("count_after_5", Frame_Count, 5);

      // Enabled but empty, then disabled but non-empty.
      quiet(50, "quiet_empty");
      Enable = 1'b0;
      push(8'h55, 1'b1);
      quiet(50, "quiet_disabled");
      chk("idle_disabled", Idle, 0);

      // Enable dropped during FETCH: byte still delivered, nothing further fetched.
      busy_len = 1;
      Enable = 1'b1;
      wait_for(0, "read_drop", r);
      Enable = 1'b0;
      push(8'h66, 1'b0);
      wait_for(1, "load_drop", l);
      chk("drop_latency", l - r, 2);
      quiet(50, "quiet_after_drop");

      // Reset during CAPTURE drops the in-flight byte.
      Enable = 1'b1;
      wait_for(0, "read_rst", r);
      @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      chk("midrst_tx_data", Tx_Data, 8'h00);
      chk("midrst_count", Frame_Count, 0);
      chk("midrst_load", Tx_Load, 0);
      chk("midrst_idle", Idle, 1);
      Reset = 1'b0;
      quiet(10, "quiet_after_rst");

      // Frame counter wraps at 4 bits.
      for (int k = 0; k < 17; k++) push(8'(8'h80 + k), 1'b1);
      for (int k = 0; k < 16; k++) wait_for(1, "wrap_load", l);
      @(negedge Clk);
      chk("count_wrap_16", Frame_Count, 0);
      wait_for(1, "wrap_load17", l);
      @(negedge Clk);
      chk("count_wrap_17", Frame_Count, 1);
      wait_for(2, "wrap_idle", i);
      chk("scoreboard_drained", exp_q.size(), 0);

      // Threshold interrupt lags its inputs by one cycle.
      Irq_En = 1'b1;
      aempty = 1'b1;
      chk("irq_lag_rise", Tx_Irq, 0);
      @(negedge Clk);
      chk("irq_high", Tx_Irq, 1);
      Irq_En = 1'b0;
      chk("irq_lag_fall", Tx_Irq, 1);
      @(negedge Clk);
      chk("irq_low", Tx_Irq, 0);
      Irq_En = 1'b1;
      aempty = 1'b0;
      @(negedge Clk);
      chk("irq_no_aempty", Tx_Irq, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
